// File: rtl/microstepper_pkg.sv
// rtl/microstepper_pkg.sv - shared chopper state encoding and default timer widths
package microstepper_pkg;

    localparam int BLANK_W = 8;
    localparam int OFF_W   = 10;

    typedef enum logic [1:0] {
        CHOP_IDLE  = 2'd0,
        CHOP_BLANK = 2'd1,
        CHOP_ON    = 2'd2,
        CHOP_OFF   = 2'd3
    } chop_state_t;

endpackage

// File: rtl/microstepper_chopper_sequencer_if.sv
// rtl/microstepper_chopper_sequencer_if.sv - per-channel control/status bundle between sequencer and channel FSM
interface microstepper_chopper_sequencer_if #(
    parameter int BLANK_W = microstepper_pkg::BLANK_W,
    parameter int OFF_W   = microstepper_pkg::OFF_W
);
    logic               enable;
    logic               phase_change;
    logic [BLANK_W-1:0] config_blank_time;
    logic [OFF_W-1:0]   config_off_time;
    logic [BLANK_W-1:0] config_minimum_on_time;
    logic               offtimer_en;
    logic [BLANK_W-1:0] blank_timer;
    logic [OFF_W-1:0]   off_timer;
    logic [BLANK_W-1:0] minimum_on_timer;
    logic [1:0]         chop_state;

    modport master (
        output enable, phase_change, config_blank_time, config_off_time,
               config_minimum_on_time, offtimer_en,
        input  blank_timer, off_timer, minimum_on_timer, chop_state
    );

    modport slave (
        input  enable, phase_change, config_blank_time, config_off_time,
               config_minimum_on_time, offtimer_en,
        output blank_timer, off_timer, minimum_on_timer, chop_state
    );
endinterface

// File: rtl/chopper_channel_fsm.sv
// rtl/chopper_channel_fsm.sv - one H-bridge chopper FSM with blank, off and minimum-on timers
module chopper_channel_fsm #(
    parameter int BLANK_W = microstepper_pkg::BLANK_W,
    parameter int OFF_W   = microstepper_pkg::OFF_W
) (
    input  logic clk,
    input  logic reset,
    microstepper_chopper_sequencer_if.slave bus
);
    import microstepper_pkg::*;

    localparam logic [1:0] S_IDLE  = CHOP_IDLE;
    localparam logic [1:0] S_BLANK = CHOP_BLANK;
    localparam logic [1:0] S_ON    = CHOP_ON;
    localparam logic [1:0] S_OFF   = CHOP_OFF;

    logic [1:0]         state;
    logic [BLANK_W-1:0] blank_q;
    logic [OFF_W-1:0]   off_q;
    logic [BLANK_W-1:0] minon_q;
    logic [BLANK_W-1:0] minon_next;
    logic [1:0]         load_state;

    assign minon_next = (minon_q != '0) ? minon_q - BLANK_W'(1) : '0;
    // A zero blank length skips BLANK entirely on every load.
    assign load_state = (bus.config_blank_time == '0) ? S_ON : S_BLANK;

    always_ff @(posedge clk) begin
        if (reset || !bus.enable) begin
            state   <= S_IDLE;
            blank_q <= '0;
            off_q   <= '0;
            minon_q <= '0;
        end else if (state == S_IDLE || bus.phase_change) begin
            state   <= load_state;
            blank_q <= bus.config_blank_time;
            minon_q <= bus.config_minimum_on_time;
            off_q   <= '0;
        end else begin
            minon_q <= minon_next;
            case (state)
                S_BLANK: begin
                    if (blank_q <= BLANK_W'(1)) begin
                        blank_q <= '0;
                        state   <= S_ON;
                    end else begin
                        blank_q <= blank_q - BLANK_W'(1);
                    end
                end
                S_ON: begin
                    if (bus.offtimer_en && bus.config_off_time != '0) begin
                        off_q <= bus.config_off_time;
                        state <= S_OFF;
                    end
                end
                S_OFF: begin
                    // Off expiry re-arms the next blank/minimum-on window in the same edge.
                    if (off_q <= OFF_W'(1)) begin
                        off_q   <= '0;
                        blank_q <= bus.config_blank_time;
                        minon_q <= bus.config_minimum_on_time;
                        state   <= load_state;
                    end else begin
                        off_q <= off_q - OFF_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.chop_state       = state;
    assign bus.blank_timer      = blank_q;
    assign bus.off_timer        = off_q;
    assign bus.minimum_on_timer = minon_q;

endmodule

// File: rtl/microstepper_chopper_sequencer.sv
// rtl/microstepper_chopper_sequencer.sv - two-bridge chopper timing sequencer fanning shared controls to two channel FSMs
module microstepper_chopper_sequencer #(
    parameter int BLANK_W = microstepper_pkg::BLANK_W,
    parameter int OFF_W   = microstepper_pkg::OFF_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               phase_change,
    input  logic [BLANK_W-1:0] config_blank_time,
    input  logic [OFF_W-1:0]   config_off_time,
    input  logic [BLANK_W-1:0] config_minimum_on_time,
    input  logic               offtimer_en0,
    input  logic               offtimer_en1,
    output logic [BLANK_W-1:0] blank_timer0,
    output logic [BLANK_W-1:0] blank_timer1,
    output logic [OFF_W-1:0]   off_timer0,
    output logic [OFF_W-1:0]   off_timer1,
    output logic [BLANK_W-1:0] minimum_on_timer0,
    output logic [BLANK_W-1:0] minimum_on_timer1,
    output logic [1:0]         chop_state0,
    output logic [1:0]         chop_state1
);
    microstepper_chopper_sequencer_if #(.BLANK_W(BLANK_W), .OFF_W(OFF_W)) bus0 ();
    microstepper_chopper_sequencer_if #(.BLANK_W(BLANK_W), .OFF_W(OFF_W)) bus1 ();

    assign bus0.enable                 = enable;
    assign bus0.phase_change           = phase_change;
    assign bus0.config_blank_time      = config_blank_time;
    assign bus0.config_off_time        = config_off_time;
    assign bus0.config_minimum_on_time = config_minimum_on_time;
    assign bus0.offtimer_en            = offtimer_en0;

    assign bus1.enable                 = enable;
    assign bus1.phase_change           = phase_change;
    assign bus1.config_blank_time      = config_blank_time;
    assign bus1.config_off_time        = config_off_time;
    assign bus1.config_minimum_on_time = config_minimum_on_time;
    assign bus1.offtimer_en            = offtimer_en1;

    chopper_channel_fsm #(.BLANK_W(BLANK_W), .OFF_W(OFF_W)) u_phase_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    chopper_channel_fsm #(.BLANK_W(BLANK_W), .OFF_W(OFF_W)) u_phase_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    assign blank_timer0      = bus0.blank_timer;
    assign off_timer0        = bus0.off_timer;
    assign minimum_on_timer0 = bus0.minimum_on_timer;
    assign chop_state0       = bus0.chop_state;
    assign blank_timer1      = bus1.blank_timer;
    assign off_timer1        = bus1.off_timer;
    assign minimum_on_timer1 = bus1.minimum_on_timer;
    assign chop_state1       = bus1.chop_state;

endmodule

// File: tb/tb_microstepper_chopper_sequencer.sv
// tb/tb_microstepper_chopper_sequencer.sv - directed bench with a timestamp-based reference model of both chopper channels
module tb_microstepper_chopper_sequencer;
    localparam int BW = 8;
    localparam int OW = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    microstepper_chopper_sequencer_if #(.BLANK_W(BW), .OFF_W(OW)) stim ();
    logic          offtimer_en1;
    logic [BW-1:0] blank_timer1;
    logic [OW-1:0] off_timer1;
    logic [BW-1:0] minimum_on_timer1;
    logic [1:0]    chop_state1;

    microstepper_chopper_sequencer #(.BLANK_W(BW), .OFF_W(OW)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .enable                 (stim.enable),
        .phase_change           (stim.phase_change),
        .config_blank_time      (stim.config_blank_time),
        .config_off_time        (stim.config_off_time),
        .config_minimum_on_time (stim.config_minimum_on_time),
        .offtimer_en0           (stim.offtimer_en),
        .offtimer_en1           (offtimer_en1),
        .blank_timer0           (stim.blank_timer),
        .blank_timer1           (blank_timer1),
        .off_timer0             (stim.off_timer),
        .off_timer1             (off_timer1),
        .minimum_on_timer0      (stim.minimum_on_timer),
        .minimum_on_timer1      (minimum_on_timer1),
        .chop_state0            (stim.chop_state),
        .chop_state1            (chop_state1)
    );

    int checks = 0;
    int passed = 0;
    bit checking = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Model: each channel remembers when its blank window and its off interval began,
    // and every timer value is derived from elapsed edges since that instant.
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_OFF  = 2;
    int mode [2] = '{M_IDLE, M_IDLE};
    int t_load [2];
    int t_off [2];
    int bl [2];
    int mn [2];
    int ol [2];
    int n = 0;

    always @(posedge clk) begin
        bit oe;
        bit was_on;
        n++;
        for (int c = 0; c < 2; c++) begin
            oe = (c == 0) ? stim.offtimer_en : offtimer_en1;
            was_on = (mode[c] == M_RUN) && ((n - 1 - t_load[c]) >= bl[c]);
            if (reset || !stim.enable) begin
                mode[c] = M_IDLE;
            end else if (mode[c] == M_IDLE || stim.phase_change ||
                         (mode[c] == M_OFF && (n - t_off[c]) >= ol[c])) begin
                mode[c]   = M_RUN;
                t_load[c] = n;
                bl[c]     = int'(stim.config_blank_time);
                mn[c]     = int'(stim.config_minimum_on_time);
            end else if (was_on && oe && stim.config_off_time != 0) begin
                mode[c]  = M_OFF;
                t_off[c] = n;
                ol[c]    = int'(stim.config_off_time);
            end
        end
    end

    function automatic int sat(input int v);
        return (v > 0) ? v : 0;
    endfunction

    always @(negedge clk) begin
        if (checking) begin
            for (int c = 0; c < 2; c++) begin
                int eb, eo, em, es;
                eb = 0; eo = 0; em = 0; es = 0;
                if (mode[c] == M_RUN) begin
                    eb = sat(bl[c] - (n - t_load[c]));
                    em = sat(mn[c] - (n - t_load[c]));
                    es = (eb > 0) ? 1 : 2;
                end else if (mode[c] == M_OFF) begin
                    eo = ol[c] - (n - t_off[c]);
                    em = sat(mn[c] - (n - t_load[c]));
                    es = 3;
                end
                if (c == 0) begin
                    chk("model blank0", int'(stim.blank_timer), eb);
                    chk("model off0", int'(stim.off_timer), eo);
                    chk("model minon0", int'(stim.minimum_on_timer), em);
                    chk("model state0", int'(stim.chop_state), es);
                end else begin
                    chk("model blank1", int'(blank_timer1), eb);
                    chk("model off1", int'(off_timer1), eo);
                    chk("model minon1", int'(minimum_on_timer1), em);
                    chk("model state1", int'(chop_state1), es);
                end
            end
        end
    end

    task automatic step(input int k);
        repeat (k) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        stim.enable = 1'b0;
        stim.phase_change = 1'b0;
        stim.offtimer_en = 1'b0;
        offtimer_en1 = 1'b0;
        stim.config_blank_time = '0;
        stim.config_off_time = '0;
        stim.config_minimum_on_time = '0;
        step(3);
        checking = 1'b1;
        reset = 1'b0;
        step(1);
        chk("reset state0", int'(stim.chop_state), 0);
        chk("reset blank0", int'(stim.blank_timer), 0);
        chk("reset off1", int'(off_timer1), 0);

        stim.config_blank_time = 8'd4;
        stim.config_off_time = 10'd10;
        stim.config_minimum_on_time = 8'd6;
        stim.enable = 1'b1;
        step(1);
        chk("enable to blank state0", int'(stim.chop_state), 1);
        chk("blank load", int'(stim.blank_timer), 4);
        chk("minon load", int'(stim.minimum_on_timer), 6);
        step(4);
        chk("blank expired", int'(stim.blank_timer), 0);
        chk("on after blank", int'(stim.chop_state), 2);

        stim.offtimer_en = 1'b1;
        step(1);
        stim.offtimer_en = 1'b0;
        chk("off load", int'(stim.off_timer), 10);
        chk("off state", int'(stim.chop_state), 3);
        step(9);
        chk("off last cycle", int'(stim.off_timer), 1);
        step(1);
        chk("off expired", int'(stim.off_timer), 0);
        chk("reblank after off", int'(stim.blank_timer), 4);
        chk("blank after off", int'(stim.chop_state), 1);

        stim.config_blank_time = 8'd2;
        stim.config_minimum_on_time = 8'd20;
        stim.phase_change = 1'b1;
        step(1);
        stim.phase_change = 1'b0;
        chk("phase reload blank0", int'(stim.blank_timer), 2);
        chk("phase reload minon0", int'(stim.minimum_on_timer), 20);
        step(2);
        chk("first on cycle", int'(stim.chop_state), 2);
        stim.offtimer_en = 1'b1;
        step(1);
        stim.offtimer_en = 1'b0;
        chk("premature off timer", int'(stim.off_timer), 10);
        chk("premature minon still running", int'(stim.minimum_on_timer), 17);

        offtimer_en1 = 1'b1;
        step(1);
        offtimer_en1 = 1'b0;
        chk("ch1 off load", int'(off_timer1), 10);
        step(5);
        chk("ch1 off mid", int'(off_timer1), 5);
        stim.phase_change = 1'b1;
        step(1);
        stim.phase_change = 1'b0;
        chk("phase in off clears off1", int'(off_timer1), 0);
        chk("phase in off blank1", int'(blank_timer1), 2);
        chk("phase in off state1", int'(chop_state1), 1);
        chk("phase reblanks ch0", int'(stim.chop_state), 1);

        stim.enable = 1'b0;
        stim.phase_change = 1'b1;
        stim.offtimer_en = 1'b1;
        offtimer_en1 = 1'b1;
        step(1);
        chk("disable wins state0", int'(stim.chop_state), 0);
        chk("disable wins state1", int'(chop_state1), 0);
        chk("disable minon0", int'(stim.minimum_on_timer), 0);
        chk("disable blank1", int'(blank_timer1), 0);
        stim.enable = 1'b1;
        stim.phase_change = 1'b0;
        stim.offtimer_en = 1'b0;
        offtimer_en1 = 1'b0;
        step(1);
        chk("reenable state0", int'(stim.chop_state), 1);
        chk("reenable state1", int'(chop_state1), 1);

        stim.config_blank_time = 8'd0;
        stim.phase_change = 1'b1;
        step(1);
        stim.phase_change = 1'b0;
        chk("zero blank straight on", int'(stim.chop_state), 2);
        chk("zero blank timer", int'(stim.blank_timer), 0);
        stim.config_off_time = 10'd0;
        stim.offtimer_en = 1'b1;
        step(1);
        stim.offtimer_en = 1'b0;
        chk("zero off stays on", int'(stim.chop_state), 2);
        chk("zero off timer", int'(stim.off_timer), 0);

        stim.config_off_time = 10'd10;
        stim.config_blank_time = 8'd3;
        stim.offtimer_en = 1'b1;
        step(1);
        stim.offtimer_en = 1'b0;
        stim.config_off_time = 10'd2;
        step(3);
        chk("mid-off config ignored", int'(stim.off_timer), 7);
        reset = 1'b1;
        step(1);
        chk("reset mid-off state0", int'(stim.chop_state), 0);
        chk("reset mid-off off0", int'(stim.off_timer), 0);
        chk("reset mid-off minon0", int'(stim.minimum_on_timer), 0);
        chk("reset mid-off state1", int'(chop_state1), 0);
        reset = 1'b0;
        step(1);
        chk("post reset blank", int'(stim.chop_state), 1);
        chk("post reset blank0", int'(stim.blank_timer), 3);

        stim.config_off_time = 10'd6;
        stim.config_minimum_on_time = 8'd9;
        for (int i = 0; i < 80; i++) begin
            stim.offtimer_en = (i % 7 == 3);
            offtimer_en1 = (i % 5 == 1);
            stim.phase_change = (i == 40);
            if (i == 55) stim.config_blank_time = 8'd1;
            step(1);
        end
        stim.offtimer_en = 1'b0;
        offtimer_en1 = 1'b0;
        stim.phase_change = 1'b0;
        step(2);

        checking = 1'b0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/microstepper_chopper_sequencer.md
# microstepper_chopper_sequencer

Per-bridge timing sequencer for the fixed-off-time peak-current chopper of the microstepper.
- Owns the blank, off and minimum-on timers for both H-bridges (channel 0 = phase A, channel 1 = phase B).
- Feeds those timers to the microstepper control datapath and consumes that datapath's `offtimer_en0/1` requests.
- Restarts blanking on every commutation (phase change) and holds all timers at zero while the driver is disabled.

## Interface
Parameters:
- `BLANK_W`, 8, width of blank and minimum-on timers
- `OFF_W`, 10, width of off timer

Ports:
- `clk` in 1: system clock
- `reset` in 1: synchronous, active-high reset
- `enable` in 1: driver enable; low forces both channels to IDLE
- `phase_change` in 1: one-cycle pulse when the microstep phase count changes; applies to both channels
- `config_blank_time` in BLANK_W: blanking length in cycles
- `config_off_time` in OFF_W: off-time length in cycles
- `config_minimum_on_time` in BLANK_W: minimum-on length in cycles
- `offtimer_en0`, `offtimer_en1` in 1: off-time start requests from the control datapath
- `blank_timer0`, `blank_timer1` out BLANK_W: remaining blank cycles
- `off_timer0`, `off_timer1` out OFF_W: remaining off cycles
- `minimum_on_timer0`, `minimum_on_timer1` out BLANK_W: remaining minimum-on cycles
- `chop_state0`, `chop_state1` out 2: current state encoding: IDLE=0, BLANK=1, ON=2, OFF=3

## Operation
- The two channels are identical and independent, except that `enable` and `phase_change` are shared.
- Per-channel FSM has four states: IDLE, BLANK, ON, OFF.
- **Reset:** all timers 0; both states IDLE.
- **IDLE:** all timers held at 0. When `enable`=1, go to BLANK with:
  - blank timer loaded from `config_blank_time`;
  - minimum-on timer loaded from `config_minimum_on_time`.
- **BLANK:**
  - The blank timer decrements each cycle. When it is 1, next state is ON (timer reaches 0).
  - A blank load value of 0 goes straight to ON; BLANK lasts 0 cycles.
- **ON:** waits for `offtimer_en`. On request:
  - off timer loads `config_off_time`; next state OFF.
  - If `config_off_time`=0, the request is ignored and the channel stays in ON.
- **OFF:**
  - The off timer decrements each cycle.
  - When it is 1, next state is BLANK; the blank and minimum-on timers reload from config and the off timer becomes 0.
- **Minimum-on timer:** decrements by 1 every cycle it is nonzero, in BLANK, ON and OFF. It saturates at 0.
  - It is NOT cleared on OFF entry, so a premature off request leaves off and minimum-on both nonzero. This intentionally exposes the fault to the downstream latch.
- **offtimer_en outside ON:** ignored in IDLE, BLANK and OFF.
- **Priority:** `enable`=0 > `phase_change` > `offtimer_en` > timer expiry.
  - `enable`=0 in any state: next cycle IDLE, all timers 0.
  - `phase_change` in BLANK, ON or OFF: off timer cleared; blank and minimum-on reload; next state BLANK.
- **Config sampling:** config values are sampled only at load instants. Changes mid-interval have no effect until the next load.
- **Arithmetic:** all decrements are unsigned, never wrap below 0, and use no widening.

## Timing
- All outputs are registered; no combinational path from any input to any output.
- **offtimer_en:** high at edge N (in ON) gives off timer = `config_off_time` and state OFF after edge N.
- **Off interval:** the off timer is nonzero for exactly `config_off_time` cycles. On the cycle it reads 0, blank is already loaded.
- **Blank interval:** the blank timer is nonzero for exactly `config_blank_time` cycles after load.
- **enable rising:** BLANK one cycle after the first cycle `enable` is sampled high.
- **Reset:** reset asserted mid-operation clears everything on the next edge and overrides every other input.

## Structure
- Shared package `microstepper_pkg`:
  - chop state enum (IDLE/BLANK/ON/OFF, 2-bit);
  - default widths `BLANK_W`/`OFF_W`.
- One sub-module `chopper_channel_fsm`, holding one channel's FSM and three timers, instantiated twice. The top level only fans out the shared `enable`, `phase_change` and config inputs.

## Test plan
- **Basic cycle:** blank=4, off=10, minon=6, enable; `offtimer_en0` pulse in ON → `blank_timer0` counts 4..1 then 0; `off_timer0`=10 the cycle after the pulse, reaches 0 ten cycles later with `blank_timer0`=4.
- **Premature off:** minon=20, blank=2, pulse `offtimer_en0` on the first ON cycle → `off_timer0`≠0 and `minimum_on_timer0`≠0 simultaneously for ≥1 cycle.
- **phase_change during OFF:** mid-OFF (`off_timer1`=5) → `off_timer1`=0, `blank_timer1`=blank config and `chop_state1`=BLANK next cycle; channel 0 also re-blanks.
- **Priority:** `enable`=0 together with `phase_change` and `offtimer_en` → both channels IDLE, all timers 0; re-enable → BLANK one cycle later.
- **Zero config:** blank=0 goes straight to ON. Off=0 with `offtimer_en` → stays ON, `off_timer`=0.
- **Reset mid-OFF:** all outputs 0 and states IDLE after one edge.
